// File: rtl/spn_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : spn_key_sched
// Brief    : Sequential round-key generator. Latches a 32-bit master key on
//            start and streams NUM_ROUNDS+1 16-bit round keys over a
//            valid/ready handshake, ascending for encrypt, descending for
//            decrypt. Ki = rotl(master_key, 4*i)[31:16].
// Revision : 1.0 - initial release
// ============================================================================
module spn_key_sched #(
    parameter int NUM_ROUNDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] master_key,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [15:0] round_key,
    output logic [3:0]  round_idx,
    output logic        key_last,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EMIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Index of the final key in an encrypt stream (first key of a decrypt stream)
    localparam logic [3:0] c_LAST_IDX = 4'(NUM_ROUNDS);
    // Decrypt starts at the last key, i.e. master key rotated by 4*NUM_ROUNDS
    localparam logic [5:0] c_DEC_ROT  = 6'((4 * NUM_ROUNDS) % 32);

    logic [1:0]  r_state;
    logic [31:0] r_key;
    logic [3:0]  r_idx;
    logic        r_mode;

    logic [63:0] w_dbl_key;
    logic [31:0] w_dec_init;
    logic        w_xfer;
    logic        w_last;

    // Constant left rotation via a doubled word: upper half of the shift is the rotated key
    assign w_dbl_key  = {master_key, master_key} << c_DEC_ROT;
    assign w_dec_init = w_dbl_key[63:32];

    assign w_last = r_mode ? (r_idx == 4'd0) : (r_idx == c_LAST_IDX);
    assign w_xfer = (r_state == c_ST_EMIT) && key_ready;

    // State, key register and index counter; the key register steps by a fixed
    // 4-bit rotation per accepted key so no barrel shifter sits in the loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_key   <= 32'd0;
            r_idx   <= 4'd0;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_key   <= mode ? w_dec_init : master_key;
                        r_idx   <= mode ? c_LAST_IDX : 4'd0;
                        r_state <= c_ST_EMIT;
                    end
                end
                c_ST_EMIT: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                        end else if (r_mode) begin
                            r_key <= {r_key[3:0], r_key[31:4]};
                            r_idx <= r_idx - 4'd1;
                        end else begin
                            r_key <= {r_key[27:0], r_key[31:28]};
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only from state and registers; no path from key_ready or start
    assign key_valid = (r_state == c_ST_EMIT);
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_DONE);
    assign round_key = r_key[31:16];
    assign round_idx = r_idx;
    assign key_last  = key_valid && w_last;

endmodule
`default_nettype wire
